// File: rtl/jtag_ir.sv
// JTAG instruction register: capture/shift/update of the IR and a combinational
// decode of the latched instruction into the active data-register selects.
module jtag_ir #(
  parameter int                   IR_WIDTH  = 4,
  parameter logic [IR_WIDTH-1:0]  EXTEST_OP = IR_WIDTH'(4'b0000),
  parameter logic [IR_WIDTH-1:0]  SAMPLE_OP = IR_WIDTH'(4'b0001),
  parameter logic [IR_WIDTH-1:0]  IDCODE_OP = IR_WIDTH'(4'b0010),
  parameter logic [IR_WIDTH-1:0]  BYPASS_OP = '1
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TDI,
  input  logic                ir_capture,
  input  logic                ir_shift,
  input  logic                ir_update,
  input  logic                test_reset,
  output logic                ir_tdo,
  output logic [IR_WIDTH-1:0] instr,
  output logic                sel_bypass,
  output logic                sel_idcode,
  output logic                sel_bsr,
  output logic                extest_mode,
  output logic                bad_op
);

  // Capture pattern: LSB 1, bit 1 0, rest zero.
  localparam logic [IR_WIDTH-1:0] CAP = IR_WIDTH'(2'b01);

  logic [IR_WIDTH-1:0] ir_sr;
  logic [IR_WIDTH-1:0] ir_q;

  // Update outranks capture/shift so a malformed strobe combination stays defined.
  always_ff @(posedge TCK) begin
    if (!TRST || test_reset) begin
      ir_sr <= CAP;
      ir_q  <= IDCODE_OP;
    end else if (ir_update) begin
      ir_q  <= ir_sr;
    end else if (ir_capture) begin
      ir_sr <= CAP;
    end else if (ir_shift) begin
      ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
    end
  end

  assign ir_tdo = ir_sr[0];
  assign instr  = ir_q;

  // Undefined opcodes fall back to BYPASS so exactly one select is always high.
  always_comb begin
    sel_bypass  = 1'b0;
    sel_idcode  = 1'b0;
    sel_bsr     = 1'b0;
    extest_mode = 1'b0;
    bad_op      = 1'b0;
    if (ir_q == IDCODE_OP) begin
      sel_idcode = 1'b1;
    end else if (ir_q == EXTEST_OP) begin
      sel_bsr     = 1'b1;
      extest_mode = 1'b1;
    end else if (ir_q == SAMPLE_OP) begin
      sel_bsr = 1'b1;
    end else if (ir_q == BYPASS_OP) begin
      sel_bypass = 1'b1;
    end else begin
      sel_bypass = 1'b1;
      bad_op     = 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_ir.sv
// Scoreboard bench for jtag_ir: a reference model predicts every post-edge
// output snapshot, which is queued and later compared with the DUT snapshot.
module tb_jtag_ir;

  logic       TCK = 1'b0;
  logic       TRST = 1'b1;
  logic       TDI = 1'b0;
  logic       ir_capture = 1'b0;
  logic       ir_shift = 1'b0;
  logic       ir_update = 1'b0;
  logic       test_reset = 1'b0;
  logic       ir_tdo;
  logic [3:0] instr;
  logic       sel_bypass, sel_idcode, sel_bsr, extest_mode, bad_op;

  jtag_ir dut (
    .TCK(TCK), .TRST(TRST), .TDI(TDI),
    .ir_capture(ir_capture), .ir_shift(ir_shift), .ir_update(ir_update),
    .test_reset(test_reset), .ir_tdo(ir_tdo), .instr(instr),
    .sel_bypass(sel_bypass), .sel_idcode(sel_idcode), .sel_bsr(sel_bsr),
    .extest_mode(extest_mode), .bad_op(bad_op)
  );

  always #5 TCK = ~TCK;

  int n_checks = 0;
  int n_fail   = 0;

  // Snapshot layout: {instr[3:0], bypass, idcode, bsr, extest, bad, tdo}
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  logic [3:0] m_sr, m_q;

  function automatic logic [9:0] model_out(input logic [3:0] q, input logic [3:0] sr);
    logic byp, idc, bsr, ext, bad;
    byp = 0; idc = 0; bsr = 0; ext = 0; bad = 0;
    case (q)
      4'b0010: idc = 1;
      4'b0000: begin bsr = 1; ext = 1; end
      4'b0001: bsr = 1;
      4'b1111: byp = 1;
      default: begin byp = 1; bad = 1; end
    endcase
    return {q, byp, idc, bsr, ext, bad, sr[0]};
  endfunction

  function automatic logic [9:0] snap();
    return {instr, sel_bypass, sel_idcode, sel_bsr, extest_mode, bad_op, ir_tdo};
  endfunction

  // Drive one edge's worth of strobes, predict, clock, record, then go idle.
  task automatic apply(input logic trst, input logic tr, input logic cap,
                       input logic sh, input logic upd, input logic tdi);
    TRST = trst; test_reset = tr; ir_capture = cap;
    ir_shift = sh; ir_update = upd; TDI = tdi;
    if (!trst || tr) begin m_sr = 4'b0001; m_q = 4'b0010; end
    else if (upd) m_q = m_sr;
    else if (cap) m_sr = 4'b0001;
    else if (sh)  m_sr = {tdi, m_sr[3:1]};
    exp_q.push_back(model_out(m_q, m_sr));
    @(posedge TCK); #1;
    obs_q.push_back(snap());
    TRST = 1; test_reset = 0; ir_capture = 0; ir_shift = 0; ir_update = 0; TDI = 0;
  endtask

  task automatic shift_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) apply(1, 0, 0, 1, 0, w[i]);
  endtask

  task automatic test_reset_state();
    logic [9:0] e, o;
    apply(0, 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reset_seq: got %b required %b", o, e); end
    end
    n_checks++;
    if (instr !== 4'b0010 || sel_idcode !== 1'b1 || ir_tdo !== 1'b1 || bad_op !== 1'b0) begin
      n_fail++; $display("FAIL reset_values: instr=%b idc=%b tdo=%b bad=%b required 0010 1 1 0",
                         instr, sel_idcode, ir_tdo, bad_op);
    end
  endtask

  task automatic test_bypass();
    logic [9:0] e, o;
    logic [3:0] tdo_seq;
    apply(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tdo_seq[i] = ir_tdo;
      apply(1, 0, 0, 1, 0, 1);
    end
    apply(1, 0, 0, 0, 1, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL bypass_seq: got %b required %b", o, e); end
    end
    n_checks++;
    if (tdo_seq !== 4'b0001) begin
      n_fail++; $display("FAIL bypass_tdo_order: got %b required 0001 (bit0 first)", tdo_seq);
    end
    n_checks++;
    if (instr !== 4'b1111 || sel_bypass !== 1'b1 || extest_mode !== 1'b0) begin
      n_fail++; $display("FAIL bypass_decode: instr=%b byp=%b ext=%b required 1111 1 0",
                         instr, sel_bypass, extest_mode);
    end
  endtask

  task automatic test_extest_sample();
    logic [9:0] e, o;
    apply(1, 0, 1, 0, 0, 0); shift_word(4'b0000); apply(1, 0, 0, 0, 1, 0);
    n_checks++;
    if (instr !== 4'b0000 || sel_bsr !== 1'b1 || extest_mode !== 1'b1) begin
      n_fail++; $display("FAIL extest_decode: instr=%b bsr=%b ext=%b required 0000 1 1",
                         instr, sel_bsr, extest_mode);
    end
    apply(1, 0, 1, 0, 0, 0); shift_word(4'b0001); apply(1, 0, 0, 0, 1, 0);
    n_checks++;
    if (instr !== 4'b0001 || sel_bsr !== 1'b1 || extest_mode !== 1'b0) begin
      n_fail++; $display("FAIL sample_decode: instr=%b bsr=%b ext=%b required 0001 1 0",
                         instr, sel_bsr, extest_mode);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL extest_sample_seq: got %b required %b", o, e); end
    end
  endtask

  task automatic test_bad_op();
    logic [9:0] e, o;
    apply(1, 0, 1, 0, 0, 0); shift_word(4'b0110); apply(1, 0, 0, 0, 1, 0);
    n_checks++;
    if (sel_bypass !== 1'b1 || bad_op !== 1'b1 || instr !== 4'b0110) begin
      n_fail++; $display("FAIL bad_op_decode: instr=%b byp=%b bad=%b required 0110 1 1",
                         instr, sel_bypass, bad_op);
    end
    apply(1, 1, 0, 0, 0, 0);
    n_checks++;
    if (instr !== 4'b0010 || bad_op !== 1'b0 || ir_tdo !== 1'b1) begin
      n_fail++; $display("FAIL test_reset_recover: instr=%b bad=%b tdo=%b required 0010 0 1",
                         instr, bad_op, ir_tdo);
    end
    // Held test_reset must override a concurrent shift on every edge.
    for (int i = 0; i < 3; i++) apply(1, 1, 0, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL bad_op_seq: got %b required %b", o, e); end
    end
  endtask

  task automatic test_trst_midshift();
    logic [9:0] e, o;
    apply(1, 0, 1, 0, 0, 0);
    apply(1, 0, 0, 1, 0, 0);
    apply(1, 0, 0, 1, 0, 0);
    apply(0, 0, 0, 1, 0, 0);
    apply(1, 0, 0, 0, 1, 0);
    n_checks++;
    if (instr !== 4'b0001 || sel_bsr !== 1'b1 || extest_mode !== 1'b0) begin
      n_fail++; $display("FAIL trst_midshift: instr=%b bsr=%b ext=%b required 0001 1 0",
                         instr, sel_bsr, extest_mode);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL trst_midshift_seq: got %b required %b", o, e); end
    end
  endtask

  task automatic test_update_shift();
    logic [9:0] e, o;
    apply(1, 0, 1, 0, 0, 0); shift_word(4'b0110);
    apply(1, 0, 0, 1, 1, 1);
    n_checks++;
    if (instr !== 4'b0110 || ir_tdo !== 1'b0) begin
      n_fail++; $display("FAIL update_shift_same_edge: instr=%b tdo=%b required 0110 0", instr, ir_tdo);
    end
    apply(1, 0, 0, 0, 1, 0);
    n_checks++;
    if (instr !== 4'b0110) begin
      n_fail++; $display("FAIL update_shift_sr_held: instr=%b required 0110", instr);
    end
    // All three strobes at once: update still wins.
    apply(1, 0, 1, 1, 1, 1);
    apply(1, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL update_shift_seq: got %b required %b", o, e); end
    end
  endtask

  initial begin
    m_sr = 4'bx; m_q = 4'bx;
    #2;
    test_reset_state();
    test_bypass();
    test_extest_sample();
    test_bad_op();
    test_trst_midshift();
    test_update_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
